// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one SRAM-like memory port between the instruction requester (I)
//   and the data requester (D). One address phase is granted at a time and
//   the grant is held until the memory accepts it. The owner of every
//   accepted transaction is pushed into an in-order ID FIFO so that each
//   memory response is routed back to the requester that issued it.
//
//   Optional feature macro: SRAM_ARB_RR_EN
//     defined   : round-robin between I and D on simultaneous requests
//                 (rr_last remembers the last granted port, resets to D).
//     undefined : fixed priority, D wins on simultaneous requests.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   i_* / d_*  (inputs)        req, wr, size, wstrb, addr, wdata per requester
//   i_addr_ok / d_addr_ok      address phase of that requester accepted
//   i_data_ok / d_data_ok      response for that requester this cycle
//   i_rdata / d_rdata          read data, zero unless the matching data_ok
//   mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
//                              shared memory request, fields of the owner
//   mem_addr_ok, mem_data_ok, mem_rdata
//                              memory handshakes, responses in accept order
//
// Requests and responses are routed combinationally (0-cycle latency);
// state, the outstanding counter, FIFO pointers and IDs are flops.
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned CNT_W     = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Owner encoding stored in the ID FIFO.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTST-1:0]   id_q, id_d;

    logic                   can_grant;
    logic                   pick;
    logic                   req_raw;
    logic                   owner;
    logic                   push;
    logic                   pop;
    logic                   head;

`ifdef SRAM_ARB_RR_EN
    logic                   rr_last_q, rr_last_d;
`endif

    // Pointer advance with wrap at MAX_OUTST (depth need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Owner choice used only when no grant is locked.
    always_comb begin
        pick = OWN_I;
`ifdef SRAM_ARB_RR_EN
        if (i_req && d_req) begin
            pick = ~rr_last_q;
        end else if (d_req) begin
            pick = OWN_D;
        end
`else
        if (d_req) begin
            pick = OWN_D;
        end
`endif
    end

    // Grant FSM, handshake routing and ID FIFO bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        id_d      = id_q;
        req_raw   = 1'b0;
        owner     = OWN_I;
`ifdef SRAM_ARB_RR_EN
        rr_last_d = rr_last_q;
`endif

        // The grant decision uses the count at the start of the cycle, so a
        // same-cycle pop never opens a slot for a same-cycle push.
        can_grant = (cnt_q < CNT_W'(MAX_OUTST));

        case (state_q)
            ST_IDLE: begin
                if (can_grant && (i_req || d_req)) begin
                    req_raw = 1'b1;
                    owner   = pick;
                    if (!mem_addr_ok) begin
                        state_d = (pick == OWN_D) ? ST_LOCK_D : ST_LOCK_I;
                    end
                end
            end
            ST_LOCK_I: begin
                req_raw = 1'b1;
                owner   = OWN_I;
                if (mem_addr_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK_D: begin
                req_raw = 1'b1;
                owner   = OWN_D;
                if (mem_addr_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Everything visible is suppressed while reset is held.
        push = req_raw && mem_addr_ok && !reset;
        pop  = mem_data_ok && (cnt_q != '0) && !reset;
        head = id_q[rd_ptr_q];

        if (push) begin
            id_d[wr_ptr_q] = owner;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
`ifdef SRAM_ARB_RR_EN
            rr_last_d      = owner;
`endif
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Shared memory request, fields taken from the current owner only.
    always_comb begin
        mem_req   = req_raw && !reset;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (mem_req) begin
            if (owner == OWN_D) begin
                mem_wr    = d_wr;
                mem_size  = d_size;
                mem_wstrb = d_wstrb;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_wr    = i_wr;
                mem_size  = i_size;
                mem_wstrb = i_wstrb;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
            end
        end
    end

    // Address-phase acknowledge and response return to the right requester.
    always_comb begin
        i_addr_ok = push && (owner == OWN_I);
        d_addr_ok = push && (owner == OWN_D);
        i_data_ok = pop && (head == OWN_I);
        d_data_ok = pop && (head == OWN_D);
        i_rdata   = i_data_ok ? mem_rdata : 32'd0;
        d_rdata   = d_data_ok ? mem_rdata : 32'd0;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            id_q      <= '0;
`ifdef SRAM_ARB_RR_EN
            rr_last_q <= OWN_D;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            id_q      <= id_d;
`ifdef SRAM_ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter (MAX_OUTST=2). A per-cycle vector table covers
// single grants, locked grants, full FIFO, same-cycle push/pop and dropped
// responses; hand-written sequences cover reset and arbitration order.
module tb_sram_req_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req, i_wr;
    logic [1:0]  i_size;
    logic [3:0]  i_wstrb;
    logic [31:0] i_addr, i_wdata;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int total;
    int bad;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic OI = 1'b0;
    localparam logic OD = 1'b1;

    sram_req_arbiter #(.MAX_OUTST(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rdata;
        logic        ereq, eown, eiaok, edaok, eidok, eddok;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ir, input logic dr, input logic aok,
                                input logic dok, input logic [31:0] rd,
                                input logic ereq, input logic eown,
                                input logic eiaok, input logic edaok,
                                input logic eidok, input logic eddok);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.ereq = ereq; v.eown = eown; v.eiaok = eiaok; v.edaok = edaok;
        v.eidok = eidok; v.eddok = eddok;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares the whole output set for one cycle.
    task automatic chk_all(input string tag, input logic ereq, input logic eown,
                           input logic eiaok, input logic edaok,
                           input logic eidok, input logic eddok,
                           input logic [31:0] rd);
        chk({tag, ".mem_req"},   32'(mem_req),   32'(ereq));
        chk({tag, ".i_addr_ok"}, 32'(i_addr_ok), 32'(eiaok));
        chk({tag, ".d_addr_ok"}, 32'(d_addr_ok), 32'(edaok));
        chk({tag, ".i_data_ok"}, 32'(i_data_ok), 32'(eidok));
        chk({tag, ".d_data_ok"}, 32'(d_data_ok), 32'(eddok));
        chk({tag, ".i_rdata"},   i_rdata, eidok ? rd : 32'd0);
        chk({tag, ".d_rdata"},   d_rdata, eddok ? rd : 32'd0);
        if (ereq) begin
            chk({tag, ".mem_addr"},  mem_addr,  (eown == OD) ? d_addr : i_addr);
            chk({tag, ".mem_wr"},    32'(mem_wr),    32'((eown == OD) ? d_wr : i_wr));
            chk({tag, ".mem_size"},  32'(mem_size),  32'((eown == OD) ? d_size : i_size));
            chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'((eown == OD) ? d_wstrb : i_wstrb));
            chk({tag, ".mem_wdata"}, mem_wdata, (eown == OD) ? d_wdata : i_wdata);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok,
                         input logic dok, input logic [31:0] rd);
        i_req = ir; d_req = dr; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Fixed requester fields, distinct so the field mux is observable.
        i_wr = 1'b0; i_size = 2'd2; i_wstrb = 4'hF; i_addr = 32'h1000_0040; i_wdata = 32'h0;
        d_wr = 1'b1; d_size = 2'd1; d_wstrb = 4'h3; d_addr = 32'h2000_0080; d_wdata = 32'hCAFE_F00D;

        //            ir dr ak dk rdata          rq own iak dak idk ddk
        vecs[0]  = mk(1, 0, 1, 0, 32'h0,         1, OI, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, OI, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h1234_5678, 0, OI, 0, 0, 1, 0);
        vecs[3]  = mk(1, 1, 0, 0, 32'h0,         1, OD, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 32'h0,         1, OD, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,         1, OD, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1, 0, 32'h0,         1, OD, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 32'h0,         1, OI, 1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 1, 0, 32'h0,         0, OI, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 32'hAAAA_0001, 0, OI, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 1, 32'hBBBB_0002, 0, OI, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 1, 0, 32'h0,         1, OI, 1, 0, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,         1, OD, 0, 1, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 32'h0,         0, OI, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 1, 1, 32'hC0C0_C0C0, 0, OI, 0, 0, 1, 0);
        vecs[15] = mk(1, 0, 1, 1, 32'hD0D0_D0D0, 1, OI, 1, 0, 0, 1);
        vecs[16] = mk(0, 1, 1, 1, 32'hE0E0_E0E0, 1, OD, 0, 1, 1, 0);
        vecs[17] = mk(0, 0, 0, 1, 32'hF0F0_F0F0, 0, OI, 0, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 1, 32'h9999_9999, 0, OI, 0, 0, 0, 0);
        vecs[19] = mk(1, 0, 1, 0, 32'h0,         1, OI, 1, 0, 0, 0);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,         1, OD, 0, 0, 0, 0);
        vecs[21] = mk(1, 1, 0, 0, 32'h0,         1, OD, 0, 0, 0, 0);

        // Reset held with every input asserted: nothing may leak out.
        reset = 1'b1;
        drive(1, 1, 1, 1, 32'hDEAD_BEEF);
        #2;
        chk_all("rst", 0, OI, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: one row per clock, outputs sampled mid-cycle.
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].ir, vecs[k].dr, vecs[k].aok, vecs[k].dok, vecs[k].rdata);
            @(negedge clk);
            chk_all($sformatf("v%0d", k), vecs[k].ereq, vecs[k].eown, vecs[k].eiaok,
                    vecs[k].edaok, vecs[k].eidok, vecs[k].eddok, vecs[k].rdata);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while locked to D with one transaction outstanding.
        reset = 1'b1;
        drive(1, 1, 1, 1, 32'h5555_5555);
        #1;
        chk_all("rlock.hold", 0, OI, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 1, 32'h5555_5555);
        #1;
        chk_all("rlock.drop", 0, OI, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        drive(1, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk_all("rlock.grant", 1, OI, 1, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 32'h7777_0001);
        @(negedge clk);
        chk_all("rlock.resp", 0, OI, 0, 0, 1, 0, 32'h7777_0001);
        @(posedge clk);
        #1;

        // Both requesting every cycle, always accepted; each response pops the
        // previous cycle's grant so the FIFO never fills.
        drive(0, 0, 0, 0, 32'h0);
        do_reset();
        begin
            logic prev_own;
            logic own;
            prev_own = OI;
            for (int k = 0; k < 6; k++) begin
                own = RR ? ((k % 2 == 0) ? OI : OD) : OD;
                drive(1, 1, 1, (k != 0), 32'h4000_0000 + 32'(k));
                @(negedge clk);
                chk_all($sformatf("arb%0d", k), 1, own, (own == OI), (own == OD),
                        (k != 0) && (prev_own == OI), (k != 0) && (prev_own == OD),
                        32'h4000_0000 + 32'(k));
                prev_own = own;
                @(posedge clk);
                #1;
            end
        end
        drive(0, 0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
